spi_master: RTL
===============

// Module: spi_master
//
// PURPOSE
// - SPI initiator driving the SS_n/MOSI/MISO frame protocol that our SPI slave + RAM wrapper accepts.
// - Turns a command handshake (2-bit cmd + 8-bit payload) into one serial frame.
// - For read-data commands, captures the 8-bit reply on MISO and returns it on rd_data.
// - Sits between the host/test sequencer and the slave wrapper's serial pins, all on one clock.
//
// PARAMETERS
// - READ_GAP  2   cycles between the last MOSI bit and the first MISO sample on RD_DATA frames; legal range 0..15
// - CNT_W     16  width of frame_cnt (used only with SPI_MASTER_FRAME_CNT_EN)
//
// PORTS
// - clk        in   1      system clock; doubles as the SPI bit clock (slave samples on posedge clk)
// - rst        in   1      asynchronous, active-high reset
// - cmd_valid  in   1      command request
// - cmd_ready  out  1      command accepted when cmd_valid && cmd_ready at posedge clk
// - cmd        in   2      00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA
// - cmd_data   in   8      payload: address or write data; don't-care content for RD_DATA, still shifted
// - rd_data    out  8      last captured read byte; holds until the next RD_DATA frame completes
// - rd_valid   out  1      one-cycle pulse when rd_data updates
// - busy       out  1      high from the cycle after acceptance until the cycle before cmd_ready rises
// - SS_n       out  1      slave select, active low
// - MOSI       out  1      serial data to slave, MSB first
// - MISO       in   1      serial data from slave
// - frame_cnt  out  CNT_W  completed-frame counter (present only with SPI_MASTER_FRAME_CNT_EN)
//
// BEHAVIOUR
// - All outputs are registered.
// - Reset values: SS_n=1, MOSI=0, cmd_ready=0 while rst is high, busy=0, rd_valid=0, rd_data=0, frame_cnt=0.
// - After reset: cmd_ready=1 in IDLE only.
// - cmd and cmd_data are latched on acceptance; later changes on these inputs are ignored.
// - FSM states: IDLE -> SEL -> SHIFT -> (GAP -> CAPTURE if cmd==RD_DATA) -> END -> IDLE.
// - SEL (1 cycle): SS_n=0, MOSI=cmd[1]. This is the read/write select bit.
// - SHIFT (10 cycles): MOSI = cmd[1], cmd[0], d7..d0.
// - Non-RD_DATA frames: SS_n is low for exactly 11 cycles.
// - GAP (READ_GAP cycles, skipped if READ_GAP is 0): SS_n=0, MOSI=0.
// - CAPTURE (8 cycles): sample MISO at each posedge, MSB first, into the shift register.
// - RD_DATA frames: SS_n is low for exactly 19+READ_GAP cycles.
// - END (1 cycle): SS_n=1, MOSI=0, busy=0.
// - END on RD_DATA frames: rd_data is loaded and rd_valid=1, in the same cycle SS_n rises.
// - IDLE: SS_n=1, cmd_ready=1.
// - Frame spacing: SS_n stays high for at least 2 cycles between frames (END + IDLE).
// - No cmd_ready during a frame; cmd_valid held high while busy is simply stalled, with no drop and no duplicate.
// - rst asserted mid-frame:
//   - immediately SS_n=1, MOSI=0, state=IDLE;
//   - the aborted frame never pulses rd_valid;
//   - rd_data returns to 0; frame_cnt is cleared.
// - Bit counter: 4 bits, counting 0..9 for SHIFT, 0..READ_GAP-1 for GAP, 0..7 for CAPTURE; no wrap beyond terminal count.
//
// CONFIGURATION
// - Macro SPI_MASTER_FRAME_CNT_EN.
// - Defined: adds port frame_cnt. It increments by 1 in END of every completed frame and wraps 2^CNT_W-1 -> 0.
// - Undefined: no frame_cnt port and no counter logic; all other behaviour is identical.
//
// STRUCTURE
// - Package wrapper_shared gains:
//   - typedef enum logic [1:0] spi_cmd_e {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA};
//   - typedef enum spi_mst_state_e {M_IDLE, M_SEL, M_SHIFT, M_GAP, M_CAPTURE, M_END};
//   - localparams FRAME_BITS=10 and READ_BITS=8.
// - One sub-module, spi_master_shift: 10-bit load/shift-out register plus 8-bit shift-in register and the bit counter.
// - spi_master keeps the FSM and the handshake.
//
// TESTING
// - WR_ADDR, cmd_data=8'hA5, accepted at cycle 0:
//   - SS_n low in cycles 1..11;
//   - MOSI = 0,0,0,1,0,1,0,0,1,0,1;
//   - SS_n high in cycle 12; cmd_ready high in cycle 13.
// - RD_DATA, READ_GAP=2, slave model drives MISO bits of 8'h3C in cycles 14..21:
//   - rd_valid=1 for one cycle with rd_data=8'h3C;
//   - SS_n rises in that same cycle.
// - WR_DATA, 8'hFF: rst pulses at cycle 5:
//   - SS_n=1 and MOSI=0 with no clock edge needed;
//   - no rd_valid;
//   - the next accepted frame is fully correct.
// - cmd_valid held high across two back-to-back RD_ADDR commands:
//   - exactly two frames;
//   - SS_n high for exactly 2 cycles between them;
//   - no second acceptance while busy=1.
// - READ_GAP=0, RD_DATA: the MISO capture starts in the cycle right after the last MOSI bit; returns 8'h81 correctly.
// - With SPI_MASTER_FRAME_CNT_EN and CNT_W=4:
//   - 17 frames -> frame_cnt ends at 1 (wrapped);
//   - without the macro, the bench compiles without the port.

Source files
------------

// File: rtl/wrapper_shared.sv
// Types and constants shared by the SPI slave wrapper and the SPI master.
package wrapper_shared;

    localparam int unsigned FRAME_BITS = 10;
    localparam int unsigned READ_BITS  = 8;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned BIT_CNT_W  = 4;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_e;

    typedef enum logic [2:0] {
        M_IDLE,
        M_SEL,
        M_SHIFT,
        M_GAP,
        M_CAPTURE,
        M_END
    } spi_mst_state_e;

    // One serial frame as it leaves the master, MSB first.
    typedef struct packed {
        spi_cmd_e            cmd;
        logic [DATA_W-1:0]   data;
    } spi_frame_t;

endpackage

// File: rtl/spi_master_shift.sv
// Datapath for spi_master: frame shift-out register, read shift-in register and bit counter.
module spi_master_shift
    import wrapper_shared::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  spi_frame_t           load_frame,
    input  logic                 shift_out,
    input  logic                 shift_in,
    input  logic                 miso,
    input  logic                 cnt_clr,
    input  logic                 cnt_inc,
    output logic                 out_msb,
    output logic                 out_next,
    output logic [READ_BITS-1:0] rx_next_c,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    logic [FRAME_BITS-1:0] tx_q;
    // The eighth read bit goes straight into the result, so only seven are held.
    logic [READ_BITS-2:0]  rx_q;

    assign out_msb   = tx_q[FRAME_BITS-1];
    assign out_next  = tx_q[FRAME_BITS-2];
    assign rx_next_c = {rx_q, miso};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q <= '0;
        end else if (load) begin
            tx_q <= load_frame;
        end else if (shift_out) begin
            tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q <= '0;
        end else if (shift_in) begin
            rx_q <= rx_next_c[READ_BITS-2:0];
        end
    end

    // Counts within one phase only; the FSM clears it before each new phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (cnt_clr) begin
            bit_cnt <= '0;
        end else if (cnt_inc) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI initiator: one command handshake becomes one SS_n/MOSI frame, RD_DATA frames capture a MISO byte.
// Optional completed-frame counter port frame_cnt under macro SPI_MASTER_FRAME_CNT_EN.
module spi_master
    import wrapper_shared::*;
#(
    parameter int unsigned READ_GAP = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              SS_n,
    output logic              MOSI,
    input  logic              MISO
`ifdef SPI_MASTER_FRAME_CNT_EN
    ,
    output logic [CNT_W-1:0]  frame_cnt
`endif
);

    localparam logic [BIT_CNT_W-1:0] SHIFT_LAST = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] CAP_LAST   = BIT_CNT_W'(READ_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] GAP_LAST   =
        BIT_CNT_W'((READ_GAP == 0) ? 32'd0 : READ_GAP - 32'd1);

    spi_mst_state_e        state_q, state_nxt;
    spi_cmd_e              cmd_q;
    spi_frame_t            req_c;

    logic                  ss_n_nxt, mosi_nxt, ready_nxt, busy_nxt, rd_valid_nxt;
    logic                  rd_load, load, shift_out, shift_in, cnt_clr, cnt_inc;
    logic                  out_msb, out_next;
    logic [READ_BITS-1:0]  rx_next_c;
    logic [BIT_CNT_W-1:0]  bit_cnt;

    assign req_c = '{cmd: spi_cmd_e'(cmd), data: cmd_data};

    spi_master_shift u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .load_frame (req_c),
        .shift_out  (shift_out),
        .shift_in   (shift_in),
        .miso       (MISO),
        .cnt_clr    (cnt_clr),
        .cnt_inc    (cnt_inc),
        .out_msb    (out_msb),
        .out_next   (out_next),
        .rx_next_c  (rx_next_c),
        .bit_cnt    (bit_cnt)
    );

    // Next-state and next-output values; outputs are registered so they line up with the state they describe.
    always_comb begin
        state_nxt    = state_q;
        ss_n_nxt     = 1'b1;
        mosi_nxt     = 1'b0;
        ready_nxt    = 1'b0;
        busy_nxt     = 1'b0;
        rd_valid_nxt = 1'b0;
        rd_load      = 1'b0;
        load         = 1'b0;
        shift_out    = 1'b0;
        shift_in     = 1'b0;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;

        unique case (state_q)
            M_IDLE: begin
                ready_nxt = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    state_nxt = M_SEL;
                    load      = 1'b1;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                    ss_n_nxt  = 1'b0;
                    mosi_nxt  = cmd[1];
                end
            end
            M_SEL: begin
                state_nxt = M_SHIFT;
                cnt_clr   = 1'b1;
                busy_nxt  = 1'b1;
                ss_n_nxt  = 1'b0;
                mosi_nxt  = out_msb;
            end
            M_SHIFT: begin
                if (bit_cnt == SHIFT_LAST) begin
                    cnt_clr = 1'b1;
                    if (cmd_q == RD_DATA) begin
                        busy_nxt = 1'b1;
                        ss_n_nxt = 1'b0;
                        if (READ_GAP == 0) begin
                            state_nxt = M_CAPTURE;
                        end else begin
                            state_nxt = M_GAP;
                        end
                    end else begin
                        state_nxt = M_END;
                    end
                end else begin
                    shift_out = 1'b1;
                    cnt_inc   = 1'b1;
                    busy_nxt  = 1'b1;
                    ss_n_nxt  = 1'b0;
                    mosi_nxt  = out_next;
                end
            end
            M_GAP: begin
                busy_nxt = 1'b1;
                ss_n_nxt = 1'b0;
                if (bit_cnt == GAP_LAST) begin
                    state_nxt = M_CAPTURE;
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            M_CAPTURE: begin
                shift_in = 1'b1;
                if (bit_cnt == CAP_LAST) begin
                    state_nxt    = M_END;
                    rd_load      = 1'b1;
                    rd_valid_nxt = 1'b1;
                end else begin
                    cnt_inc  = 1'b1;
                    busy_nxt = 1'b1;
                    ss_n_nxt = 1'b0;
                end
            end
            M_END: begin
                state_nxt = M_IDLE;
                ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = M_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= M_IDLE;
            cmd_q     <= WR_ADDR;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state_q   <= state_nxt;
            SS_n      <= ss_n_nxt;
            MOSI      <= mosi_nxt;
            cmd_ready <= ready_nxt;
            busy      <= busy_nxt;
            rd_valid  <= rd_valid_nxt;
            if (load) begin
                cmd_q <= req_c.cmd;
            end
            if (rd_load) begin
                rd_data <= rx_next_c;
            end
        end
    end

`ifdef SPI_MASTER_FRAME_CNT_EN
    // END lasts one cycle, so entering it marks exactly one completed frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (state_nxt == M_END) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end
`endif

endmodule
